// File: rtl/cmp_seq_pkg.sv
// Shared types and default widths for the compare-sequence driver.
// State encoding lives here so the driver and its bench agree on it.
package cmp_seq_pkg;

    localparam int CW_DEF = 17;
    localparam int SW_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_GAPW = 3'd3,
        S_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with a zero flag.
// Times the idle gap between consecutive step pulses.
module gap_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cmp_seq_driver.sv
// Drives step pulses and a compare-select vector into a counter/comparator,
// stopping on match, step limit or abort.
module cmp_seq_driver
    import cmp_seq_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int SW  = SW_DEF,
    parameter int GAP = 0
) (
    input  logic          CK,
    input  logic          RN,
    input  logic          START,
    input  logic          ABORT,
    input  logic [CW-1:0] SEL,
    input  logic [SW-1:0] MAX_STEPS,
    input  logic          Z,
    output logic          P_0,
    output logic [CW-1:0] C,
    output logic          BUSY,
    output logic          DONE,
    output logic          HIT,
    output logic [SW-1:0] STEPS
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    // Timer is loaded with GAP-1 so that GAPW spans exactly GAP cycles
    localparam logic [GW-1:0] GAP_LD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_limit;
    logic [SW-1:0] r_steps;
    logic [CW-1:0] r_c;
    logic          r_p0;
    logic          r_done;
    logic          r_hit;
    logic [SW-1:0] w_step_inc;
    logic          w_at_limit;
    logic          w_start_ok;
    logic          w_gap_load;
    logic          w_gap_dec;
    logic          w_gap_zero;
    logic          w_hit_set;

    assign w_step_inc = r_steps + SW'(1);
    assign w_at_limit = (w_step_inc == r_limit);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (MAX_STEPS == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = ABORT ? S_FIN : S_STEP;
            end
            S_STEP: begin
                if (ABORT || Z || w_at_limit) begin
                    w_next = S_FIN;
                end else if (GAP > 0) begin
                    w_next = S_GAPW;
                end else begin
                    w_next = S_STEP;
                end
            end
            S_GAPW: begin
                if (ABORT) begin
                    w_next = S_FIN;
                end else if (w_gap_zero) begin
                    w_next = S_STEP;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_start_ok = (r_state == S_IDLE) && START;
        w_gap_load = (r_state == S_STEP) && (w_next == S_GAPW);
        w_gap_dec  = (r_state == S_GAPW);
        // Abort outranks a coincident match
        w_hit_set  = (r_state == S_STEP) && !ABORT && Z;
        BUSY       = (r_state != S_IDLE);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_c     <= '0;
            r_limit <= '0;
            r_steps <= '0;
            r_hit   <= 1'b0;
            r_p0    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_c     <= SEL;
                r_limit <= MAX_STEPS;
                r_steps <= '0;
                r_hit   <= 1'b0;
            end else if (r_state == S_STEP) begin
                r_steps <= w_step_inc;
                if (w_hit_set) begin
                    r_hit <= 1'b1;
                end
            end
            r_p0   <= (w_next == S_STEP);
            r_done <= (w_next == S_FIN);
        end
    end

    gap_timer #(
        .W(GW)
    ) u_gap (
        .i_clk   (CK),
        .i_rst_n (RN),
        .i_load  (w_gap_load),
        .i_val   (GAP_LD),
        .i_dec   (w_gap_dec),
        .o_zero  (w_gap_zero)
    );

    assign P_0   = r_p0;
    assign DONE  = r_done;
    assign C     = r_c;
    assign HIT   = r_hit;
    assign STEPS = r_steps;

endmodule

// File: tb/tb_cmp_seq_driver.sv
// Bench for cmp_seq_driver: a GAP=0 instance and a GAP=2 instance,
// each run checked against a scoreboard of expected outcomes.
module tb_cmp_seq_driver;

    typedef struct {
        logic        hit;
        logic [15:0] steps;
        logic [16:0] c;
        logic [31:0] pat;
        int          dcyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic        CK = 1'b0;
    logic        RN = 1'b0;

    logic        st_a = 1'b0;
    logic        ab_a = 1'b0;
    logic [16:0] sel_a = '0;
    logic [15:0] max_a = '0;
    logic        z_a = 1'b0;
    logic        p_a;
    logic [16:0] c_a;
    logic        busy_a;
    logic        done_a;
    logic        hit_a;
    logic [15:0] steps_a;

    logic        st_b = 1'b0;
    logic        ab_b = 1'b0;
    logic [16:0] sel_b = '0;
    logic [15:0] max_b = '0;
    logic        z_b = 1'b0;
    logic        p_b;
    logic [16:0] c_b;
    logic        busy_b;
    logic        done_b;
    logic        hit_b;
    logic [15:0] steps_b;

    always #5 CK = ~CK;

    cmp_seq_driver u_dut_a (
        .CK        (CK),
        .RN        (RN),
        .START     (st_a),
        .ABORT     (ab_a),
        .SEL       (sel_a),
        .MAX_STEPS (max_a),
        .Z         (z_a),
        .P_0       (p_a),
        .C         (c_a),
        .BUSY      (busy_a),
        .DONE      (done_a),
        .HIT       (hit_a),
        .STEPS     (steps_a)
    );

    cmp_seq_driver #(
        .GAP(2)
    ) u_dut_b (
        .CK        (CK),
        .RN        (RN),
        .START     (st_b),
        .ABORT     (ab_b),
        .SEL       (sel_b),
        .MAX_STEPS (max_b),
        .Z         (z_b),
        .P_0       (p_b),
        .C         (c_b),
        .BUSY      (busy_b),
        .DONE      (done_b),
        .HIT       (hit_b),
        .STEPS     (steps_b)
    );

    // z_at / ab_at: pulse number on which Z / ABORT is raised (0 = never,
    // ab_at < 0 = abort during LOAD). rs_at: pulse on which a stray START
    // with a different SEL/MAX_STEPS is driven.
    task automatic run_a(input logic [16:0] sel, input logic [15:0] mx,
                         input int z_at, input int ab_at, input int rs_at);
        exp_t        e;
        logic [31:0] pat;
        int          pc;
        int          dcyc;
        logic        p;
        logic        d;
        pat  = '0;
        pc   = 0;
        dcyc = 0;
        @(negedge CK);
        sel_a = sel;
        max_a = mx;
        st_a  = 1'b1;
        @(negedge CK);
        st_a = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            p = p_a;
            d = done_a;
            if (k == 1) begin
                n_vec++;
                if (busy_a !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_after_start: got %b want 1", busy_a);
                end
            end
            if (p) pc++;
            pat  = {pat[30:0], p};
            z_a  = p && (pc == z_at);
            ab_a = ((ab_at < 0) && (k == 1)) || (p && (pc == ab_at));
            if (p && (pc == rs_at)) begin
                st_a  = 1'b1;
                sel_a = 17'h1ABCD;
                max_a = 16'd1;
            end else begin
                st_a = 1'b0;
            end
            if (d) begin
                dcyc = k;
                break;
            end
            @(negedge CK);
        end
        z_a  = 1'b0;
        ab_a = 1'b0;
        st_a = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (dcyc !== e.dcyc) begin
            n_err++;
            $display("FAIL done_cycle: got %0d want %0d", dcyc, e.dcyc);
        end
        n_vec++;
        if (pat !== e.pat) begin
            n_err++;
            $display("FAIL pulse_pattern: got %b want %b", pat, e.pat);
        end
        n_vec++;
        if (hit_a !== e.hit) begin
            n_err++;
            $display("FAIL hit: got %b want %b", hit_a, e.hit);
        end
        n_vec++;
        if (steps_a !== e.steps) begin
            n_err++;
            $display("FAIL steps: got %0d want %0d", steps_a, e.steps);
        end
        n_vec++;
        if (c_a !== e.c) begin
            n_err++;
            $display("FAIL c_vector: got %h want %h", c_a, e.c);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge CK);
            n_vec++;
            if ({p_a, done_a, busy_a} !== 3'b000) begin
                n_err++;
                $display("FAIL idle_quiet: p/done/busy got %b want 000",
                         {p_a, done_a, busy_a});
            end
        end
        n_vec++;
        if ({hit_a, steps_a, c_a} !== {e.hit, e.steps, e.c}) begin
            n_err++;
            $display("FAIL idle_hold: hit %b steps %0d c %h want %b %0d %h",
                     hit_a, steps_a, c_a, e.hit, e.steps, e.c);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        repeat (2) @(negedge CK);
        n_vec++;
        if ({p_a, c_a, busy_a, done_a, hit_a, steps_a} !== '0) begin
            n_err++;
            $display("FAIL reset_a: p %b c %h busy %b done %b hit %b steps %0d want all 0",
                     p_a, c_a, busy_a, done_a, hit_a, steps_a);
        end
        n_vec++;
        if ({p_b, c_b, busy_b, done_b, hit_b, steps_b} !== '0) begin
            n_err++;
            $display("FAIL reset_b: p %b c %h busy %b done %b hit %b steps %0d want all 0",
                     p_b, c_b, busy_b, done_b, hit_b, steps_b);
        end
        RN = 1'b1;
        @(negedge CK);
    endtask

    task automatic test_hit();
        sb.push_back('{1'b1, 16'd5, 17'h00020, 32'h3E, 7});
        run_a(17'h00020, 16'd10, 5, 0, 0);
    endtask

    task automatic test_back_to_back();
        sb.push_back('{1'b0, 16'd3, 17'h1FFFF, 32'h0E, 5});
        run_a(17'h1FFFF, 16'd3, 0, 0, 0);
    endtask

    task automatic test_zero_limit();
        sb.push_back('{1'b0, 16'd0, 17'h15555, 32'h0, 1});
        run_a(17'h15555, 16'd0, 0, 0, 0);
    endtask

    task automatic test_hit_at_limit();
        sb.push_back('{1'b1, 16'd1, 17'h00001, 32'h2, 3});
        run_a(17'h00001, 16'd1, 1, 0, 0);
    endtask

    task automatic test_abort();
        sb.push_back('{1'b0, 16'd4, 17'h00003, 32'h1E, 6});
        run_a(17'h00003, 16'd100, 4, 4, 0);
        sb.push_back('{1'b0, 16'd0, 17'h00777, 32'h0, 2});
        run_a(17'h00777, 16'd5, 0, -1, 0);
    endtask

    task automatic test_start_busy();
        sb.push_back('{1'b0, 16'd4, 17'h0AAAA, 32'h1E, 6});
        run_a(17'h0AAAA, 16'd4, 0, 0, 1);
    endtask

    task automatic test_gap();
        exp_t        e;
        logic [31:0] pat;
        int          dcyc;
        pat  = '0;
        dcyc = 0;
        sb.push_back('{1'b0, 16'd3, 17'h12345, 32'h092, 9});
        @(negedge CK);
        sel_b = 17'h12345;
        max_b = 16'd3;
        st_b  = 1'b1;
        @(negedge CK);
        st_b = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            pat = {pat[30:0], p_b};
            if (done_b) begin
                dcyc = k;
                break;
            end
            @(negedge CK);
        end
        e = sb.pop_front();
        n_vec++;
        if (dcyc !== e.dcyc) begin
            n_err++;
            $display("FAIL gap_done_cycle: got %0d want %0d", dcyc, e.dcyc);
        end
        n_vec++;
        if (pat !== e.pat) begin
            n_err++;
            $display("FAIL gap_pattern: got %b want %b", pat, e.pat);
        end
        n_vec++;
        if ({hit_b, steps_b, c_b} !== {e.hit, e.steps, e.c}) begin
            n_err++;
            $display("FAIL gap_result: hit %b steps %0d c %h want %b %0d %h",
                     hit_b, steps_b, c_b, e.hit, e.steps, e.c);
        end
        @(negedge CK);
        n_vec++;
        if (busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL gap_idle_busy: got %b want 0", busy_b);
        end
    endtask

    task automatic test_reset_mid();
        int   pc;
        logic hit_rst;
        pc      = 0;
        hit_rst = 1'b0;
        @(negedge CK);
        sel_a = 17'h00444;
        max_a = 16'd8;
        st_a  = 1'b1;
        @(negedge CK);
        st_a = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (p_a) pc++;
            if (pc == 2) begin
                hit_rst = 1'b1;
                break;
            end
            @(negedge CK);
        end
        n_vec++;
        if (!hit_rst) begin
            n_err++;
            $display("FAIL reset_mid_pulse2: got %0d pulses want 2", pc);
        end
        RN = 1'b0;
        #1;
        n_vec++;
        if ({p_a, c_a, busy_a, done_a, hit_a, steps_a} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async: p %b c %h busy %b done %b hit %b steps %0d want all 0",
                     p_a, c_a, busy_a, done_a, hit_a, steps_a);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge CK);
            n_vec++;
            if (done_a !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_no_done: got %b want 0", done_a);
            end
        end
        RN = 1'b1;
        sb.push_back('{1'b0, 16'd2, 17'h00444, 32'h6, 4});
        run_a(17'h00444, 16'd2, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_zero_limit();
        test_back_to_back();
        test_hit_at_limit();
        test_abort();
        test_start_busy();
        test_gap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_seq_driver.md
CMP_SEQ_DRIVER -- requirements
Module: cmp_seq_driver

Interface
REQ-001 SHALL have parameter CW, default 17, the width of the compare-select vector C.
REQ-002 SHALL have parameter SW, default 16, the width of the step limit and step count.
REQ-003 SHALL have parameter GAP, default 0, the number of idle cycles (P_0=0) between consecutive step pulses.
REQ-004 SHALL have port CK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RN  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port START  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 SHALL have port ABORT  input  1  terminates an active run.
REQ-008 SHALL have port SEL  input  CW  compare-select pattern, captured at START.
REQ-009 SHALL have port MAX_STEPS  input  SW  step-pulse limit, captured at START.
REQ-010 SHALL have port Z  input  1  match flag returned by the counter/comparator under drive.
REQ-011 SHALL have port P_0  output  1  step-enable pulse to the counter.
REQ-012 SHALL have port C  output  CW  registered compare-select vector driven to the counter.
REQ-013 SHALL have port BUSY  output  1  high in every state other than IDLE.
REQ-014 SHALL have port DONE  output  1  one-cycle completion strobe.
REQ-015 SHALL have port HIT  output  1  1 when the last run ended on Z; 0 when it ended on limit or abort.
REQ-016 SHALL have port STEPS  output  SW  number of P_0 pulses issued in the last or current run.

Function
REQ-017 SHALL implement states IDLE, LOAD, STEP, GAPW, FIN.
REQ-018 In IDLE, START=1 SHALL capture SEL into C and MAX_STEPS into a limit register, clear STEPS and HIT, and go to LOAD.
REQ-019 If START=1 and MAX_STEPS=0, the block SHALL skip LOAD and go directly to FIN with HIT=0 and STEPS=0, and SHALL issue no pulse.
REQ-020 LOAD SHALL last exactly 1 cycle with P_0=0 (C settling) and then go to STEP.
REQ-021 STEP SHALL last exactly 1 cycle with P_0=1, and STEPS SHALL increment by 1 at the edge that ends it.
REQ-022 Z SHALL be sampled only at the edge that ends a STEP cycle.
REQ-023 If Z=1 at that edge, HIT SHALL be set to 1 and the state SHALL go to FIN.
REQ-024 Else, if the incremented STEPS equals the limit, the state SHALL go to FIN with HIT=0.
REQ-025 Else the state SHALL go to GAPW when GAP>0, otherwise back to STEP, so that with GAP=0 pulses are issued on back-to-back cycles.
REQ-026 GAPW SHALL hold P_0=0 for exactly GAP cycles and then go to STEP.
REQ-027 FIN SHALL assert DONE for exactly 1 cycle and then go to IDLE.
REQ-028 C, HIT and STEPS SHALL hold their values in IDLE until the next accepted START.
REQ-029 STEPS SHALL never wrap; the limit check guarantees STEPS ≤ MAX_STEPS ≤ 2^SW−1.
REQ-030 ABORT=1 in LOAD, STEP or GAPW SHALL force FIN on the next edge with HIT=0.
REQ-031 If ABORT=1 during a STEP cycle, no hit SHALL be recorded (abort takes priority over Z) and STEPS SHALL still count that pulse.
REQ-032 ABORT in IDLE or FIN, and START while BUSY=1, SHALL be ignored.
REQ-033 P_0 and DONE SHALL be driven directly from flops and SHALL not be combinational paths from any input.

Reset
REQ-034 While RN=0, the block SHALL hold state IDLE, P_0=0, C=0, BUSY=0, DONE=0, HIT=0 and STEPS=0, with the limit register and gap counter at 0.
REQ-035 An RN assertion mid-run SHALL abandon the run immediately, without a DONE strobe.
REQ-036 Operation SHALL resume on the first rising CK edge after RN deasserts.

Structure
REQ-037 The state encoding and the default CW and SW values SHALL live in a shared package (cmp_seq_pkg).
REQ-038 The GAPW delay SHALL be implemented as one sub-module, gap_timer (loadable down-counter with a zero flag).
REQ-039 All other logic SHALL be flat within cmp_seq_driver.

Verification
REQ-040 The bench model SHALL assert Z during the 5th P_0 pulse; with SEL=17'h00020, MAX_STEPS=10, GAP=0 -> exactly 5 consecutive P_0 cycles starting 2 cycles after START, C=17'h00020, DONE 1 cycle after the 5th pulse, HIT=1, STEPS=5.
REQ-041 With Z held 0, MAX_STEPS=3 and GAP=2 -> pulse pattern 1,0,0,1,0,0,1 followed by DONE, HIT=0, STEPS=3.
REQ-042 START with MAX_STEPS=0 -> no P_0 pulse, DONE 1 cycle after START, HIT=0, STEPS=0.
REQ-043 MAX_STEPS=100 with ABORT pulsed on the same cycle as the 4th pulse, while Z=1 -> HIT=0, STEPS=4, DONE on the next cycle, no further pulses.
REQ-044 RN driven low after the 2nd pulse of a run with MAX_STEPS=8 -> all outputs 0 asynchronously, no DONE; a new START after release runs normally from STEPS=0.
REQ-045 A second START while BUSY=1 -> ignored; C and the limit keep their first-run values.
